// File: rtl/morph_win_ctrl.sv
// Frame controller for the 3x3 erode/dilate filters: tracks row/col, flags complete windows, sequences mode changes.
// Latency: lb_clr/frame_err/active_mode 1 clk after in_vs rise; win_valid DELAY clks after its in_de sample.
// Backpressure: none; follows the free-running video timing and never stalls it.
module morph_win_ctrl #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int DELAY    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vs,
    input  logic       in_hs,
    input  logic       in_de,
    input  logic       cfg_en,
    input  logic [1:0] cfg_mode,
    input  logic       cfg_update,
    output logic [1:0] active_mode,
    output logic       lb_clr,
    output logic       win_valid,
    output logic [8:0] row,
    output logic [8:0] col,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic {IDLE, FRAME} state_t;

    localparam logic [8:0] H_MAX  = 9'(H_ACTIVE);
    localparam logic [8:0] H_LAST = 9'(H_ACTIVE - 1);
    localparam logic [8:0] V_MAX  = 9'(V_ACTIVE);

    state_t       state;
    logic         vs_d;
    logic         de_d;
    logic         line_err;
    logic [1:0]   pend_mode;
    logic [DELAY-1:0] win_sr;

    logic         vs_rise;
    logic         de_fall;
    logic         in_frame;
    logic [8:0]   col_nxt;
    logic         raw_win;
    logic         hs_unused;

    assign hs_unused = in_hs;
    assign vs_rise   = in_vs & ~vs_d;
    assign de_fall   = ~in_de & de_d;
    assign in_frame  = (state == FRAME);

    // col_nxt is the index of the pixel being sampled now, so the window
    // test below sees the same coordinate that col will show next cycle.
    always_comb begin
        col_nxt = 9'd0;
        if (!de_d)
            col_nxt = 9'd0;
        else if (col == H_MAX)
            col_nxt = H_MAX;
        else
            col_nxt = col + 9'd1;
    end

    assign raw_win = in_frame & in_de & ~vs_rise & (active_mode != 2'd0)
                   & (row >= 9'd2) & (col_nxt >= 9'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            vs_d        <= 1'b0;
            de_d        <= 1'b0;
            lb_clr      <= 1'b0;
            frame_err   <= 1'b0;
            line_err    <= 1'b0;
            pend_mode   <= 2'd0;
            active_mode <= 2'd0;
            row         <= 9'd0;
            col         <= 9'd0;
        end else begin
            vs_d      <= in_vs;
            de_d      <= in_de;
            lb_clr    <= 1'b0;
            frame_err <= 1'b0;
            if (cfg_update)
                pend_mode <= cfg_mode;

            if (vs_rise) begin
                // Only a frame we actually tracked is judged for geometry.
                if (state == FRAME)
                    frame_err <= line_err | (row != V_MAX);
                row <= 9'd0;
                col <= 9'd0;
                if (cfg_en) begin
                    state       <= FRAME;
                    busy        <= 1'b1;
                    lb_clr      <= 1'b1;
                    line_err    <= 1'b0;
                    active_mode <= cfg_update ? cfg_mode : pend_mode;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (state == FRAME) begin
                if (in_de) begin
                    col <= col_nxt;
                    if (de_d && (col_nxt == H_MAX))
                        line_err <= 1'b1;
                end else if (de_fall) begin
                    col <= 9'd0;
                    if (row != V_MAX)
                        row <= row + 9'd1;
                    if (col != H_LAST)
                        line_err <= 1'b1;
                end
            end
        end
    end

    generate
        if (DELAY == 1) begin : g_delay_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    win_sr <= '0;
                else
                    win_sr <= raw_win;
            end
        end else begin : g_delay_n
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    win_sr <= '0;
                else
                    win_sr <= {win_sr[DELAY-2:0], raw_win};
            end
        end
    endgenerate

    assign win_valid = win_sr[DELAY-1];

endmodule

// File: tb/tb_morph_win_ctrl.sv
// Directed bench for morph_win_ctrl on a reduced 8x4 geometry with DELAY = 4.
// Expected values come from the stimulus coordinates and hand-derived frame outcomes.
module tb_morph_win_ctrl;

    localparam int H = 8;
    localparam int V = 4;
    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic       in_vs;
    logic       in_hs;
    logic       in_de;
    logic       cfg_en;
    logic [1:0] cfg_mode;
    logic       cfg_update;
    logic [1:0] active_mode;
    logic       lb_clr;
    logic       win_valid;
    logic [8:0] row;
    logic [8:0] col;
    logic       frame_err;
    logic       busy;

    morph_win_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DELAY(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_hs(in_hs), .in_de(in_de),
        .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_update(cfg_update),
        .active_mode(active_mode), .lb_clr(lb_clr), .win_valid(win_valid),
        .row(row), .col(col), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       checks;
    int       errors;
    int       cyc;
    int       wv_cnt;
    bit       exp_raw [0:4095];
    bit       exp_lb;
    bit       exp_fe;
    bit       frm_on;
    logic [1:0] exp_mode;
    logic [1:0] pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // One clock: sample after the edge, check the per-cycle pulse outputs.
    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        idx = cyc - (D - 1);
        chk("win_valid", {31'd0, win_valid}, (idx >= 0) ? {31'd0, exp_raw[idx]} : 32'd0);
        chk("lb_clr", {31'd0, lb_clr}, {31'd0, exp_lb});
        chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
        if (win_valid) wv_cnt++;
        exp_lb = 1'b0;
        exp_fe = 1'b0;
        cfg_update = 1'b0;
        cyc++;
    endtask

    task automatic px(input bit vs, input bit de, input int r, input int c);
        in_vs = vs;
        in_de = de;
        in_hs = ~de;
        exp_raw[cyc] = de && frm_on && (exp_mode != 2'd0) && (r >= 2) && (c >= 2);
        tick();
    endtask

    task automatic chk_rc(input string tag, input int r, input int c);
        chk({tag, "_row"}, {23'd0, row}, frm_on ? r : 0);
        chk({tag, "_col"}, {23'd0, col}, frm_on ? c : 0);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_row", {23'd0, row}, 0);
        chk("rst_col", {23'd0, col}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_mode", {30'd0, active_mode}, 0);
        chk("rst_win", {31'd0, win_valid}, 0);
        chk("rst_lb", {31'd0, lb_clr}, 0);
        chk("rst_fe", {31'd0, frame_err}, 0);
        for (int i = cyc - D; i < cyc; i++)
            if (i >= 0) exp_raw[i] = 1'b0;
        frm_on = 1'b0;
        exp_mode = 2'd0;
        pend = 2'd0;
        px(0, 0, 0, 0);
        rst_n = 1'b1;
        px(0, 0, 0, 0);
        px(0, 0, 0, 0);
    endtask

    task automatic send_frame(input int nlines, input int short_ln, input bit en, input bit fe,
                              input bit upd, input logic [1:0] upd_mode, input bit vs_de,
                              input int rst_ln, input int rst_px);
        logic [1:0] new_mode;
        int len;
        int c0;
        cfg_en = en;
        exp_lb = en;
        exp_fe = fe;
        if (upd) begin
            cfg_update = 1'b1;
            cfg_mode = upd_mode;
        end
        new_mode = en ? (upd ? upd_mode : pend) : exp_mode;
        if (upd) pend = upd_mode;
        wv_cnt = 0;
        px(1, vs_de, 0, 0);
        frm_on = en;
        exp_mode = new_mode;
        chk("vs_mode", {30'd0, active_mode}, {30'd0, exp_mode});
        chk("vs_busy", {31'd0, busy}, {31'd0, en});
        chk_rc("vs", 0, 0);
        if (!vs_de) begin
            px(0, 0, 0, 0);
            chk_rc("pre", 0, 0);
        end
        for (int r = 0; r < nlines; r++) begin
            len = (r == short_ln) ? H - 1 : H;
            c0 = (r == 0 && vs_de) ? 1 : 0;
            for (int c = c0; c < len; c++) begin
                if (r == rst_ln && c == rst_px) begin
                    mid_reset();
                    return;
                end
                px(0, 1, r, c);
                chk_rc("pix", r, c);
            end
            for (int b = 0; b < 2; b++) begin
                px(0, 0, 0, 0);
                chk_rc("blank", (r + 1 > V) ? V : r + 1, 0);
            end
        end
        px(0, 0, 0, 0);
        px(0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        wv_cnt = 0;
        exp_lb = 1'b0;
        exp_fe = 1'b0;
        frm_on = 1'b0;
        exp_mode = 2'd0;
        pend = 2'd0;
        rst_n = 1'b0;
        in_vs = 1'b0;
        in_hs = 1'b0;
        in_de = 1'b0;
        cfg_en = 1'b0;
        cfg_mode = 2'd0;
        cfg_update = 1'b0;

        #3;
        chk("reset_mode", {30'd0, active_mode}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_row", {23'd0, row}, 0);
        chk("reset_col", {23'd0, col}, 0);
        chk("reset_win", {31'd0, win_valid}, 0);
        px(0, 0, 0, 0);
        px(0, 0, 0, 0);
        rst_n = 1'b1;
        px(0, 0, 0, 0);

        // Load mode 1 while idle, then a clean 8x4 erode frame.
        cfg_update = 1'b1;
        cfg_mode = 2'd1;
        pend = 2'd1;
        px(0, 0, 0, 0);
        send_frame(4, -1, 1, 0, 0, 2'd0, 0, -1, -1);
        chk("wv_count_a", wv_cnt, 12);

        // Mid-frame update must not take effect before the next frame start.
        cfg_update = 1'b1;
        cfg_mode = 2'd2;
        pend = 2'd2;
        px(0, 0, 0, 0);
        chk("mode_hold", {30'd0, active_mode}, 1);
        px(0, 0, 0, 0);
        chk("mode_hold2", {30'd0, active_mode}, 1);

        // Dilate frame with a 7-pixel line 1; reported at the next frame start.
        send_frame(4, 1, 1, 0, 0, 2'd0, 0, -1, -1);
        chk("wv_count_b", wv_cnt, 12);
        // Only three lines; reported at the next frame start.
        send_frame(3, -1, 1, 1, 0, 2'd0, 0, -1, -1);
        chk("wv_count_c", wv_cnt, 6);
        // Disable at frame start: leaves FRAME, still judges the 3-line frame.
        send_frame(4, -1, 0, 1, 0, 2'd0, 0, -1, -1);
        chk("wv_count_d", wv_cnt, 0);

        cfg_update = 1'b1;
        cfg_mode = 2'd0;
        pend = 2'd0;
        px(0, 0, 0, 0);
        send_frame(4, -1, 0, 0, 0, 2'd0, 0, -1, -1);
        chk("wv_count_e", wv_cnt, 0);
        chk("idle_busy", {31'd0, busy}, 0);

        // Bypass frame: counters run, no window flags.
        send_frame(4, -1, 1, 0, 0, 2'd0, 0, -1, -1);
        chk("wv_count_f", wv_cnt, 0);

        // Update coincident with frame start and pixel 0; reset in line 1.
        send_frame(4, -1, 1, 0, 1, 2'd1, 1, 1, 3);

        // First frame after reset: no geometry check despite the cut frame.
        send_frame(4, -1, 1, 0, 1, 2'd1, 1, -1, -1);
        chk("wv_count_h", wv_cnt, 12);
        send_frame(4, -1, 1, 0, 0, 2'd0, 0, -1, -1);
        chk("wv_count_i", wv_cnt, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
